// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared constants for the serial sample loader and the floating-point
// converter that consumes its output. Both blocks size their sample paths
// from DATA_W, so a change of sample width stays consistent across them.
//   DATA_W    : sample width in bits (two's-complement)
//   CNT_W     : width of the loader's received-bit counter
//   ST_*      : loader FSM state encoding
//   LAST_BIT  : counter value while the final data bit is being received
//   FULL_CNT  : counter value once all data bits have been received
// ---------------------------------------------------------------------------
package fp_pkg;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;  // reachable only with PARITY_CHECK_EN
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

endpackage

// File: rtl/serial_sample_loader.sv
// ---------------------------------------------------------------------------
// serial_sample_loader
// Assembles an MSB-first serial bit stream into a DATA_W-bit two's-complement
// sample and presents it on a valid/ready output register.
//
// Ports
//   clk           in   rising-edge system clock
//   rst_n         in   asynchronous active-low reset
//   ser_start     in   one-cycle frame-start strobe (aborts a frame in flight)
//   ser_bit_valid in   qualifies ser_bit for one cycle
//   ser_bit       in   serial data, MSB first
//   d_out         out  assembled sample, stable while d_valid is high
//   d_valid       out  d_out holds an unconsumed sample
//   d_ready       in   consumer takes d_out when d_valid && d_ready
//   busy          out  high whenever the FSM is not in IDLE
//   frame_err     out  one-cycle pulse when a frame is discarded
//
// Build option
//   PARITY_CHECK_EN : when defined, every frame carries a trailing even-parity
//                     bit covering all 13 bits; a mismatch discards the word.
//                     When undefined, frames are exactly DATA_W bits.
// ---------------------------------------------------------------------------
module serial_sample_loader
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_start,
  input  logic              ser_bit_valid,
  input  logic              ser_bit,
  output logic [DATA_W-1:0] d_out,
  output logic              d_valid,
  input  logic              d_ready,
  output logic              busy,
  output logic              frame_err
);

  logic [1:0]        state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [DATA_W-1:0] shreg_q,     shreg_d;
  logic [DATA_W-1:0] d_out_q,     d_out_d;
  logic              d_valid_q,   d_valid_d;
  logic              frame_err_q, frame_err_d;
`ifdef PARITY_CHECK_EN
  logic              par_q,       par_d;     // running XOR of the data bits
`endif

  logic [DATA_W-1:0] shifted_word;
  logic              complete_req;
  logic [DATA_W-1:0] complete_word;

  assign shifted_word = {shreg_q[DATA_W-2:0], ser_bit};

  // NOTE: every variable gets a default before the case statement so that no
  // path leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    d_out_d       = d_out_q;
    // The output register empties on a handshake unless a load below refills it.
    d_valid_d     = d_valid_q && !d_ready;
    frame_err_d   = 1'b0;
    complete_req  = 1'b0;
    complete_word = shreg_q;
`ifdef PARITY_CHECK_EN
    par_d         = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ser_start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
`ifdef PARITY_CHECK_EN
          par_d   = 1'b0;
`endif
        end
      end

      ST_SHIFT: begin
        // ser_start wins over a coincident bit: the bit belongs to the
        // aborted frame and is dropped.
        if (ser_start) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          shreg_d     = '0;
`ifdef PARITY_CHECK_EN
          par_d       = 1'b0;
`endif
        end else if (ser_bit_valid) begin
          shreg_d = shifted_word;
`ifdef PARITY_CHECK_EN
          par_d   = par_q ^ ser_bit;
`endif
          if (cnt_q == LAST_BIT) begin
            // Counter saturates at FULL_CNT; it is only cleared by a new start.
            cnt_d = FULL_CNT;
`ifdef PARITY_CHECK_EN
            state_d = ST_PARITY;
`else
            complete_req  = 1'b1;
            complete_word = shifted_word;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

`ifdef PARITY_CHECK_EN
      ST_PARITY: begin
        if (ser_start) begin
          state_d     = ST_SHIFT;
          frame_err_d = 1'b1;
          cnt_d       = '0;
          shreg_d     = '0;
          par_d       = 1'b0;
        end else if (ser_bit_valid) begin
          // Even parity: data XOR plus the parity bit must be zero.
          if (par_q ^ ser_bit) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            complete_req  = 1'b1;
            complete_word = shreg_q;
          end
        end
      end
`endif

      ST_HOLD: begin
        // The held word sits in shreg_q; it moves out once the register has
        // been observed empty, i.e. the cycle after the handshake.
        if (!d_valid_q) begin
          d_out_d   = shreg_q;
          d_valid_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A finished word loads straight into the output register if it is empty
    // or being emptied this edge; otherwise it waits in HOLD.
    if (complete_req) begin
      if (!d_valid_q || d_ready) begin
        d_out_d   = complete_word;
        d_valid_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        shreg_d = complete_word;
        state_d = ST_HOLD;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      d_out_q     <= '0;
      d_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      d_out_q     <= d_out_d;
      d_valid_q   <= d_valid_d;
      frame_err_q <= frame_err_d;
`ifdef PARITY_CHECK_EN
      par_q       <= par_d;
`endif
    end
  end

  assign d_out     = d_out_q;
  assign d_valid   = d_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_sample_loader.sv
// ---------------------------------------------------------------------------
// tb_serial_sample_loader
// Self-checking bench for serial_sample_loader. The reference model is a
// transaction-level one: every frame that should survive pushes its word onto
// an expected queue, and each output handshake must deliver the head of that
// queue. Discarded frames are counted and compared against frame_err pulses.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// or on the falling edge.
// ---------------------------------------------------------------------------
module tb_serial_sample_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ser_start;
  logic        ser_bit_valid;
  logic        ser_bit;
  logic        d_ready;
  logic [11:0] d_out;
  logic        d_valid;
  logic        busy;
  logic        frame_err;

  int          errors = 0;
  int          checks = 0;
  logic [11:0] exp_q[$];
  int          ferr_seen = 0;
  bit          rand_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [11:0] prev_dout;

  serial_sample_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ser_start     (ser_start),
    .ser_bit_valid (ser_bit_valid),
    .ser_bit       (ser_bit),
    .d_out         (d_out),
    .d_valid       (d_valid),
    .d_ready       (d_ready),
    .busy          (busy),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  // Output monitor: scoreboard on handshakes, stability while stalled,
  // frame_err pulse counting.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (d_valid !== 1'b1 || d_out !== prev_dout) begin
          errors++;
          $display("FAIL stall_stable: d_valid=%b d_out=%h, required d_valid=1 d_out=%h",
                   d_valid, d_out, prev_dout);
        end
      end
      if (frame_err === 1'b1) ferr_seen++;
      if (d_valid === 1'b1 && d_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got d_out=%h, required no output", d_out);
        end else begin
          logic [11:0] w;
          w = exp_q.pop_front();
          if (d_out !== w) begin
            errors++;
            $display("FAIL word_order: got d_out=%h, required %h", d_out, w);
          end
        end
      end
      prev_stall = (d_valid === 1'b1 && d_ready !== 1'b1);
      prev_dout  = d_out;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_ready) d_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic start_frame();
    ser_start = 1'b1;
    cyc();
    ser_start = 1'b0;
  endtask

  task automatic send_bits(input logic [11:0] word, input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      ser_bit       = word[11-i];
      ser_bit_valid = 1'b1;
      cyc();
      ser_bit_valid = 1'b0;
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) cyc();
    end
  endtask

  task automatic send_parity(input logic b);
`ifdef PARITY_CHECK_EN
    ser_bit       = b;
    ser_bit_valid = 1'b1;
    cyc();
    ser_bit_valid = 1'b0;
`else
    ser_bit = b;
`endif
  endtask

  // Full frame with a correct trailing parity bit when parity is built in.
  task automatic send_frame(input logic [11:0] word, input int max_gap);
    start_frame();
    send_bits(word, 12, max_gap);
    send_parity(^word);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      cyc();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ser_start = 1'b0; ser_bit_valid = 1'b0; ser_bit = 1'b0; d_ready = 1'b1;
    #1;
    checks++;
    if (d_out !== 12'h000 || d_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: d_out=%h d_valid=%b busy=%b frame_err=%b, required 000/0/0/0",
               d_out, d_valid, busy, frame_err);
    end
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    d_ready = 1'b1;
    exp_q.push_back(12'h800);
    send_frame(12'h800, 0);
    checks++;
    if (d_valid !== 1'b1 || d_out !== 12'h800 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: d_valid=%b d_out=%h busy=%b, required 1/800/0",
               d_valid, d_out, busy);
    end
    cyc();
    checks++;
    if (d_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_consumed: d_valid=%b busy=%b, required 0/0", d_valid, busy);
    end
  endtask

  task automatic test_hold();
    d_ready = 1'b0;
    exp_q.push_back(12'h7FF);
    exp_q.push_back(12'h001);
    send_frame(12'h7FF, 0);
    checks++;
    if (d_valid !== 1'b1 || d_out !== 12'h7FF) begin
      errors++;
      $display("FAIL hold_first: d_valid=%b d_out=%h, required 1/7ff", d_valid, d_out);
    end
    send_frame(12'h001, 0);
    checks++;
    if (busy !== 1'b1 || d_valid !== 1'b1 || d_out !== 12'h7FF) begin
      errors++;
      $display("FAIL hold_entered: busy=%b d_valid=%b d_out=%h, required 1/1/7ff",
               busy, d_valid, d_out);
    end
    // Start strobe and a stray bit while holding must both be ignored.
    start_frame();
    send_bits(12'hFFF, 1, 0);
    checks++;
    if (frame_err !== 1'b0 || busy !== 1'b1 || d_out !== 12'h7FF) begin
      errors++;
      $display("FAIL hold_ignores_input: frame_err=%b busy=%b d_out=%h, required 0/1/7ff",
               frame_err, busy, d_out);
    end
    d_ready = 1'b1;
    cyc();
    d_ready = 1'b0;
    checks++;
    if (d_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_after_handshake: d_valid=%b busy=%b, required 0/1", d_valid, busy);
    end
    cyc();
    checks++;
    if (d_valid !== 1'b1 || d_out !== 12'h001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: d_valid=%b d_out=%h busy=%b, required 1/001/0",
               d_valid, d_out, busy);
    end
    d_ready = 1'b1;
    cyc();
  endtask

  task automatic test_abort();
    int base;
    d_ready = 1'b1;
    base = ferr_seen;
    start_frame();
    send_bits(12'(($urandom)), 5, 0);
    start_frame();
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pulse: frame_err=%b busy=%b, required 1/1", frame_err, busy);
    end
    exp_q.push_back(12'hABC);
    send_bits(12'hABC, 12, 0);
    send_parity(^12'hABC);
    checks++;
    if (d_valid !== 1'b1 || d_out !== 12'hABC) begin
      errors++;
      $display("FAIL abort_then_word: d_valid=%b d_out=%h, required 1/abc", d_valid, d_out);
    end
    cyc();
    checks++;
    if (ferr_seen - base !== 1) begin
      errors++;
      $display("FAIL abort_err_count: saw %0d frame_err pulses, required 1", ferr_seen - base);
    end
  endtask

  task automatic test_length();
`ifdef PARITY_CHECK_EN
    d_ready = 1'b1;
    exp_q.push_back(12'h003);
    start_frame();
    send_bits(12'h003, 12, 0);
    send_parity(1'b0);
    checks++;
    if (d_valid !== 1'b1 || d_out !== 12'h003) begin
      errors++;
      $display("FAIL parity_good: d_valid=%b d_out=%h, required 1/003", d_valid, d_out);
    end
    cyc();
    start_frame();
    send_bits(12'h003, 12, 0);
    send_parity(1'b1);
    checks++;
    if (frame_err !== 1'b1 || d_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL parity_bad: frame_err=%b d_valid=%b busy=%b, required 1/0/0",
               frame_err, d_valid, busy);
    end
    cyc();
    checks++;
    if (d_valid !== 1'b0) begin
      errors++;
      $display("FAIL parity_bad_no_word: d_valid=%b, required 0", d_valid);
    end
`else
    // Exactly 12 bits complete a word; a 13th bit lands in IDLE and is dropped.
    d_ready = 1'b1;
    exp_q.push_back(12'h003);
    start_frame();
    send_bits(12'h003, 12, 0);
    checks++;
    if (d_valid !== 1'b1 || d_out !== 12'h003 || busy !== 1'b0) begin
      errors++;
      $display("FAIL length_12: d_valid=%b d_out=%h busy=%b, required 1/003/0",
               d_valid, d_out, busy);
    end
    send_bits(12'hFFF, 1, 0);
    cyc();
    checks++;
    if (d_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL length_extra_bit: d_valid=%b busy=%b frame_err=%b, required 0/0/0",
               d_valid, busy, frame_err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    d_ready = 1'b1;
    start_frame();
    send_bits(12'hFFF, 7, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || d_valid !== 1'b0 || d_out !== 12'h000 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: busy=%b d_valid=%b d_out=%h frame_err=%b, required 0/0/000/0",
               busy, d_valid, d_out, frame_err);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    // Reset while holding: both the output word and the held word vanish.
    d_ready = 1'b0;
    send_frame(12'h123, 0);
    send_frame(12'h456, 0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (busy !== 1'b0 || d_valid !== 1'b0 || d_out !== 12'h000) begin
      errors++;
      $display("FAIL reset_in_hold: busy=%b d_valid=%b d_out=%h, required 0/0/000",
               busy, d_valid, d_out);
    end
    cyc();
    rst_n = 1'b1;
    d_ready = 1'b1;
    send_bits(12'hABC, 12, 0);
    send_parity(^12'hABC);
    cyc();
    checks++;
    if (d_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_stale: d_valid=%b busy=%b, required 0/0", d_valid, busy);
    end
    exp_q.push_back(12'hFFF);
    send_frame(12'hFFF, 0);
    checks++;
    if (d_valid !== 1'b1 || d_out !== 12'hFFF) begin
      errors++;
      $display("FAIL reset_then_word: d_valid=%b d_out=%h, required 1/fff", d_valid, d_out);
    end
    cyc();
  endtask

  task automatic test_same_cycle();
    d_ready = 1'b1;
    // From IDLE: the start is taken and the coincident bit is dropped.
    exp_q.push_back(12'h555);
    ser_start = 1'b1; ser_bit_valid = 1'b1; ser_bit = 1'b1;
    cyc();
    ser_start = 1'b0; ser_bit_valid = 1'b0;
    send_bits(12'h555, 12, 0);
    send_parity(^12'h555);
    checks++;
    if (d_valid !== 1'b1 || d_out !== 12'h555) begin
      errors++;
      $display("FAIL same_cycle_idle: d_valid=%b d_out=%h, required 1/555", d_valid, d_out);
    end
    cyc();
    // Mid-frame: abort wins over the bit.
    start_frame();
    send_bits(12'hE00, 3, 0);
    ser_start = 1'b1; ser_bit_valid = 1'b1; ser_bit = 1'b1;
    cyc();
    ser_start = 1'b0; ser_bit_valid = 1'b0;
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_abort: frame_err=%b, required 1", frame_err);
    end
    exp_q.push_back(12'h2AA);
    send_bits(12'h2AA, 12, 0);
    send_parity(^12'h2AA);
    checks++;
    if (d_valid !== 1'b1 || d_out !== 12'h2AA) begin
      errors++;
      $display("FAIL same_cycle_shift: d_valid=%b d_out=%h, required 1/2aa", d_valid, d_out);
    end
    cyc();
  endtask

  task automatic test_random();
    int          base;
    int          exp_err = 0;
    logic [11:0] w;
    base = ferr_seen;
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      wait_idle();
      w = 12'($urandom);
      start_frame();
      if ($urandom_range(0, 3) == 0) begin
        send_bits(12'($urandom), $urandom_range(1, 11), 2);
        ser_start     = 1'b1;
        ser_bit_valid = 1'($urandom);
        ser_bit       = 1'($urandom);
        cyc();
        ser_start     = 1'b0;
        ser_bit_valid = 1'b0;
        exp_err++;
      end
`ifdef PARITY_CHECK_EN
      begin
        bit bad;
        bad = ($urandom_range(0, 4) == 0);
        if (bad) exp_err++;
        else     exp_q.push_back(w);
        send_bits(w, 12, 2);
        send_parity((^w) ^ bad);
      end
`else
      exp_q.push_back(w);
      send_bits(w, 12, 2);
`endif
    end
    wait_idle();
    rand_ready = 1'b0;
    d_ready    = 1'b1;
    repeat (4) cyc();
    checks++;
    if (ferr_seen - base !== exp_err) begin
      errors++;
      $display("FAIL random_err_count: saw %0d frame_err pulses, required %0d",
               ferr_seen - base, exp_err);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: %0d words never delivered, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_abort();
    test_length();
    test_reset_mid();
    test_same_cycle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
